// File: rtl/sram_b_port_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM port arbiter.
package sram_b_arb_pkg;

  localparam int NREQ        = 2;
  localparam int SRAM_RD_LAT = 1;

  typedef logic [$clog2(NREQ)-1:0] req_idx_t;

  // Observable arbiter state: round-robin pointers and reads awaiting Q1.
  typedef struct packed {
    req_idx_t          wr_ptr;
    req_idx_t          rd_ptr;
    logic [NREQ-1:0]   inflight;
  } arb_dbg_t;

  function automatic req_idx_t other_req(input req_idx_t r);
    return ~r;
  endfunction

endpackage

// File: rtl/sram_b_port_arbiter_if.sv
// Requester-side bus of the arbiter: write, read and response channels per requester.
interface sram_b_port_arbiter_if #(
  parameter int ABITS = 8,
  parameter int DBITS = 8
);
  import sram_b_arb_pkg::*;

  // Every channel is valid/ready: a transfer happens on a cycle where both are
  // high. wr_ready/rd_ready are combinational grants; rsp_valid is a registered
  // slot that holds its data until the requester raises rsp_ready.
  logic [NREQ-1:0]       wr_valid;
  logic [NREQ-1:0]       wr_ready;
  logic [NREQ*ABITS-1:0] wr_addr;
  logic [NREQ*DBITS-1:0] wr_data;
  logic [NREQ*DBITS-1:0] wr_mask;
  logic [NREQ-1:0]       rd_valid;
  logic [NREQ-1:0]       rd_ready;
  logic [NREQ*ABITS-1:0] rd_addr;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*DBITS-1:0] rsp_data;
  arb_dbg_t              dbg;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, dbg
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_data, dbg
  );

endinterface

// File: rtl/sram_b_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured requester.
module rr_arb2
  import sram_b_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] gnt_o,
  output req_idx_t        ptr_o
);

  req_idx_t ptr_q, ptr_d;
  req_idx_t win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // After a grant the other requester becomes favoured.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = other_req(win);
  end

  always_comb begin
    gnt_o = req_i;
    if (&req_i) gnt_o = (ptr_q == req_idx_t'(1)) ? 2'b10 : 2'b01;
  end

  assign win   = req_idx_t'(gnt_o[1]);
  assign ptr_o = ptr_q;

endmodule

// File: rtl/sram_b_port_arbiter.sv
// Shares a 1w:1r SRAM between two requesters with independent round-robin
// write and read arbitration and a one-entry registered response slot each.
module sram_b_port_arbiter
  import sram_b_arb_pkg::*;
#(
  parameter int ABITS = 8,
  parameter int DBITS = 8,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  sram_b_port_arbiter_if.slave bus,
  output logic             CE0,
  output logic [ABITS-1:0] A0,
  output logic [DBITS-1:0] D0,
  output logic             WE0,
  output logic [DBITS-1:0] WEM0,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1,
  output logic [CNTW-1:0]  stall_cnt
);

  logic [NREQ-1:0]       wr_req, wr_gnt;
  logic [NREQ-1:0]       rd_elig, rd_gnt, rd_issue;
  logic [NREQ-1:0]       inflight_q, inflight_d;
  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NREQ*DBITS-1:0] rsp_data_q, rsp_data_d;
  logic [CNTW-1:0]       stall_q, stall_d;
  logic [ABITS-1:0]      rd_sel_addr;
  logic                  conflict;
  req_idx_t              wr_ptr, rd_ptr;

  // ---------------- write port ----------------
  assign wr_req = bus.wr_valid & {NREQ{~RST}};

  rr_arb2 u_wr_arb (
    .clk       (CLK),
    .rst       (RST),
    .req_i     (wr_req),
    .advance_i (|wr_gnt),
    .gnt_o     (wr_gnt),
    .ptr_o     (wr_ptr)
  );

  always_comb begin
    CE0  = 1'b0;
    WE0  = 1'b0;
    A0   = '0;
    D0   = '0;
    WEM0 = '0;
    if (wr_gnt[0]) begin
      CE0  = 1'b1;
      WE0  = 1'b1;
      A0   = bus.wr_addr[ABITS-1:0];
      D0   = bus.wr_data[DBITS-1:0];
      WEM0 = bus.wr_mask[DBITS-1:0];
    end else if (wr_gnt[1]) begin
      CE0  = 1'b1;
      WE0  = 1'b1;
      A0   = bus.wr_addr[2*ABITS-1:ABITS];
      D0   = bus.wr_data[2*DBITS-1:DBITS];
      WEM0 = bus.wr_mask[2*DBITS-1:DBITS];
    end
  end

  assign bus.wr_ready = wr_gnt;

  // ---------------- read port ----------------
  // A requester may issue only if its previous read has landed and its slot
  // is empty or draining this cycle.
  assign rd_elig = bus.rd_valid & ~inflight_q & (~rsp_valid_q | bus.rsp_ready)
                 & {NREQ{~RST}};

  rr_arb2 u_rd_arb (
    .clk       (CLK),
    .rst       (RST),
    .req_i     (rd_elig),
    .advance_i (CE1),
    .gnt_o     (rd_gnt),
    .ptr_o     (rd_ptr)
  );

  // A read hitting the address being written this cycle waits one cycle,
  // so it observes the new data and the SRAM never sees a same-address clash.
  always_comb begin
    rd_sel_addr = rd_gnt[1] ? bus.rd_addr[2*ABITS-1:ABITS] : bus.rd_addr[ABITS-1:0];
    conflict    = (|rd_gnt) && CE0 && WE0 && (rd_sel_addr == A0);
    rd_issue    = conflict ? '0 : rd_gnt;
    CE1         = |rd_issue;
    A1          = CE1 ? rd_sel_addr : '0;
  end

  assign bus.rd_ready = rd_issue;

  // ---------------- response slots and stall counter ----------------
  always_comb begin
    inflight_d  = rd_issue;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int r = 0; r < NREQ; r++) begin
      if (inflight_q[r]) begin
        rsp_valid_d[r]                = 1'b1;
        rsp_data_d[r*DBITS +: DBITS]  = Q1;
      end else if (bus.rsp_ready[r]) begin
        rsp_valid_d[r] = 1'b0;
      end
    end
    stall_d = stall_q;
    if (conflict && !(&stall_q)) stall_d = stall_q + CNTW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      stall_q     <= '0;
    end else begin
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign stall_cnt     = stall_q;

  always_comb begin
    bus.dbg          = '0;
    bus.dbg.wr_ptr   = wr_ptr;
    bus.dbg.rd_ptr   = rd_ptr;
    bus.dbg.inflight = inflight_q;
  end

endmodule

// File: tb/tb_sram_b_port_arbiter.sv
// Directed bench for sram_b_port_arbiter with an SRAM model and response scoreboard.
module tb_sram_b_port_arbiter;
  import sram_b_arb_pkg::*;

  localparam int ABITS = 8;
  localparam int DBITS = 8;
  localparam int CNTW  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             CE0, WE0, CE1;
  logic [ABITS-1:0] A0, A1;
  logic [DBITS-1:0] D0, WEM0, Q1;
  logic [CNTW-1:0]  stall_cnt;

  sram_b_port_arbiter_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

  sram_b_port_arbiter #(.ABITS(ABITS), .DBITS(DBITS), .CNTW(CNTW)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .CE0       (CE0),
    .A0        (A0),
    .D0        (D0),
    .WE0       (WE0),
    .WEM0      (WEM0),
    .CE1       (CE1),
    .A1        (A1),
    .Q1        (Q1),
    .stall_cnt (stall_cnt)
  );

  // SRAM model: masked write on port 0, registered read on port 1.
  logic [DBITS-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    Q1 = '0;
  end
  always @(posedge clk) begin
    if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
    if (CE1) Q1 <= mem[A1];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [DBITS-1:0] exp_q0[$];
  logic [DBITS-1:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DBITS-1:0] mon_got, mon_want;
  always @(negedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 2; r++) begin
        if (bus.rsp_valid[r] && bus.rsp_ready[r]) begin
          mon_got = bus.rsp_data[r*DBITS +: DBITS];
          if ((r == 0 && exp_q0.size() == 0) || (r == 1 && exp_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: requester %0d got 0x%0h with no expected entry", r, mon_got);
          end else begin
            mon_want = (r == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("rsp_data_r%0d", r), 32'(mon_got), 32'(mon_want));
          end
        end
      end
      if (CE0 && WE0 && CE1) check("sram_addr_clash", 32'(A1 == A0), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.wr_valid  = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_mask   = '0;
    bus.rd_valid  = '0;
    bus.rd_addr   = '0;
    bus.rsp_ready = 2'b11;
  endtask

  task automatic wr(input int r, input logic [7:0] a, input logic [7:0] d, input logic [7:0] m);
    bus.wr_valid[r]               = 1'b1;
    bus.wr_addr[r*ABITS +: ABITS] = a;
    bus.wr_data[r*DBITS +: DBITS] = d;
    bus.wr_mask[r*DBITS +: DBITS] = m;
  endtask

  task automatic rd(input int r, input logic [7:0] a);
    bus.rd_valid[r]               = 1'b1;
    bus.rd_addr[r*ABITS +: ABITS] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.wr_valid = 2'b11;
    bus.rd_valid = 2'b11;
    sample();
    check("rst_wr_ready",  32'(bus.wr_ready),  0);
    check("rst_rd_ready",  32'(bus.rd_ready),  0);
    check("rst_ce0",       32'(CE0),           0);
    check("rst_we0",       32'(WE0),           0);
    check("rst_a0",        32'(A0),            0);
    check("rst_ce1",       32'(CE1),           0);
    check("rst_a1",        32'(A1),            0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data",  32'(bus.rsp_data),  0);
    check("rst_stall",     32'(stall_cnt),     0);
    check("rst_dbg",       32'(bus.dbg),       0);
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    next_cycle();

    // Both requesters write continuously: grants alternate starting at 0.
    for (int i = 0; i < 4; i++) begin
      wr(0, 8'h10, 8'(8'hA0 + i), 8'hFF);
      wr(1, 8'h20, 8'(8'hB0 + i), 8'hFF);
      sample();
      check("t1_wr_ready", 32'(bus.wr_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("t1_ce0",      32'(CE0), 1);
      check("t1_we0",      32'(WE0), 1);
      check("t1_a0",       32'(A0),  (i % 2 == 0) ? 32'h10 : 32'h20);
      check("t1_d0",       32'(D0),  (i % 2 == 0) ? 32'hA0 + i : 32'hB0 + i);
      next_cycle();
    end
    clear_inputs();
    wr(1, 8'h20, 8'hFF, 8'h0F);
    sample();
    check("mask_wr_ready", 32'(bus.wr_ready), 32'h2);
    check("mask_wem0",     32'(WEM0),         32'h0F);
    next_cycle();
    clear_inputs();
    sample();
    check("t1_mem_10", 32'(mem[8'h10]), 32'hA2);
    check("t1_mem_20", 32'(mem[8'h20]), 32'hBF);
    next_cycle();

    // Write then read back: two-cycle issue-to-response latency.
    wr(0, 8'h33, 8'hA5, 8'hFF);
    sample();
    check("t2_wr_ready", 32'(bus.wr_ready), 32'h1);
    next_cycle();
    clear_inputs();
    rd(0, 8'h33);
    exp_q0.push_back(8'hA5);
    sample();
    check("t2_rd_ready", 32'(bus.rd_ready), 32'h1);
    check("t2_ce1",      32'(CE1), 1);
    check("t2_a1",       32'(A1),  32'h33);
    check("t2_idle_ce0", 32'(CE0), 0);
    check("t2_idle_a0",  32'(A0),  0);
    check("t2_idle_d0",  32'(D0),  0);
    next_cycle();
    clear_inputs();
    sample();
    check("t2_rsp_early", 32'(bus.rsp_valid), 0);
    next_cycle();
    sample();
    check("t2_rsp_valid", 32'(bus.rsp_valid[0]), 1);
    check("t2_rsp_data",  32'(bus.rsp_data[7:0]), 32'hA5);
    next_cycle();

    // Same-cycle write and read to one address: read deferred by a cycle.
    wr(0, 8'h40, 8'h5A, 8'hFF);
    rd(1, 8'h40);
    sample();
    check("t3_rd_ready", 32'(bus.rd_ready), 0);
    check("t3_ce1",      32'(CE1), 0);
    check("t3_wr_ready", 32'(bus.wr_ready), 32'h1);
    check("t3_ce0",      32'(CE0), 1);
    next_cycle();
    bus.wr_valid = '0;
    exp_q1.push_back(8'h5A);
    sample();
    check("t3_stall",     32'(stall_cnt), 1);
    check("t3_rd_retry",  32'(bus.rd_ready), 32'h2);
    check("t3_a1",        32'(A1), 32'h40);
    next_cycle();
    clear_inputs();
    next_cycle();
    sample();
    check("t3_rsp_valid", 32'(bus.rsp_valid[1]), 1);
    check("t3_rsp_data",  32'(bus.rsp_data[15:8]), 32'h5A);
    next_cycle();

    // Requester 1 back-pressures its response slot.
    wr(1, 8'h50, 8'h77, 8'hFF);
    next_cycle();
    clear_inputs();
    wr(1, 8'h60, 8'h66, 8'hFF);
    next_cycle();
    clear_inputs();
    bus.rsp_ready = 2'b01;
    rd(1, 8'h50);
    exp_q1.push_back(8'h77);
    sample();
    check("t4_issue", 32'(bus.rd_ready), 32'h2);
    next_cycle();
    rd(1, 8'h60);
    sample();
    check("t4_inflight_block", 32'(bus.rd_ready), 0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t4_hold_valid", 32'(bus.rsp_valid[1]), 1);
      check("t4_hold_data",  32'(bus.rsp_data[15:8]), 32'h77);
      check("t4_hold_block", 32'(bus.rd_ready), 0);
      next_cycle();
    end
    bus.rsp_ready = 2'b11;
    exp_q1.push_back(8'h66);
    sample();
    check("t4_drain_issue", 32'(bus.rd_ready), 32'h2);
    check("t4_drain_a1",    32'(A1), 32'h60);
    next_cycle();
    clear_inputs();
    sample();
    check("t4_slot_empty", 32'(bus.rsp_valid[1]), 0);
    next_cycle();
    sample();
    check("t4_rsp2_valid", 32'(bus.rsp_valid[1]), 1);
    check("t4_rsp2_data",  32'(bus.rsp_data[15:8]), 32'h66);
    next_cycle();

    // Both requesters read back-to-back: CE1 every cycle, grants alternate.
    wr(0, 8'h80, 8'hC0, 8'hFF);
    next_cycle();
    clear_inputs();
    wr(1, 8'h81, 8'hC1, 8'hFF);
    next_cycle();
    clear_inputs();
    rd(0, 8'h80);
    rd(1, 8'h81);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) exp_q0.push_back(8'hC0);
      else            exp_q1.push_back(8'hC1);
      sample();
      check("t5_ce1",      32'(CE1), 1);
      check("t5_rd_ready", 32'(bus.rd_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("t5_a1",       32'(A1), (i % 2 == 0) ? 32'h80 : 32'h81);
      next_cycle();
    end
    clear_inputs();
    repeat (3) begin
      sample();
      next_cycle();
    end
    check("t5_all_rsp_seen", 32'(exp_q0.size() + exp_q1.size()), 0);

    // Reset while a read is in flight: its data must never land.
    check("t6_stall_before", 32'(stall_cnt), 1);
    rd(0, 8'h80);
    sample();
    check("t6_issue", 32'(bus.rd_ready), 32'h1);
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    sample();
    check("t6_rst_rsp", 32'(bus.rsp_valid), 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t6_rsp_valid", 32'(bus.rsp_valid), 0);
      check("t6_stall",     32'(stall_cnt), 0);
      check("t6_dbg",       32'(bus.dbg), 0);
      next_cycle();
    end
    wr(0, 8'h90, 8'h11, 8'hFF);
    wr(1, 8'h91, 8'h22, 8'hFF);
    rd(0, 8'h80);
    rd(1, 8'h81);
    exp_q0.push_back(8'hC0);
    sample();
    check("t6_wr_favour0", 32'(bus.wr_ready), 32'h1);
    check("t6_rd_favour0", 32'(bus.rd_ready), 32'h1);
    next_cycle();
    clear_inputs();
    repeat (3) begin
      sample();
      next_cycle();
    end
    check("final_q_empty", 32'(exp_q0.size() + exp_q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_b_port_arbiter.md
Name: sram_b_port_arbiter

Overview:
- Shares one 1w:1r 256x8 ESP SRAM wrapper (write port 0, read port 1, 1-cycle read latency) between two requesters.
- Each requester has an independent write channel and read channel, with valid/ready handshakes.
- Round-robin arbitration runs separately on the write port and the read port. Read data is returned through a registered one-entry response slot per requester.
- The block defers same-cycle read/write to the same address, so the memory address-conflict assertion can never fire.

Parameters:
- ABITS, 8, address width of the SRAM wrapper.
- DBITS, 8, data/mask width of the SRAM wrapper.
- CNTW, 16, width of the saturating conflict-stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- wr_valid  in  2  per-requester write request.
- wr_ready  out  2  write accepted this cycle (one-hot or zero).
- wr_addr  in  2*ABITS  write address, requester r at [r*ABITS +: ABITS].
- wr_data  in  2*DBITS  write data.
- wr_mask  in  2*DBITS  write bit mask.
- rd_valid  in  2  per-requester read request.
- rd_ready  out  2  read issued to the SRAM this cycle (one-hot or zero).
- rd_addr  in  2*ABITS  read address.
- rsp_valid  out  2  response slot full.
- rsp_ready  in  2  requester consumes the response.
- rsp_data  out  2*DBITS  response data.
- CE0, A0, D0, WE0, WEM0  out  1/ABITS/DBITS/1/DBITS  SRAM write port.
- CE1, A1  out  1/ABITS  SRAM read port.
- Q1  in  DBITS  SRAM read data, valid the cycle after CE1.
- stall_cnt  out  CNTW  number of read grants deferred by address conflict; saturates at all-ones.

Behaviour:
- Reset:
  - Both round-robin pointers favour requester 0.
  - inflight[1:0]=0 and rsp_valid=0.
  - rsp_data=0 and stall_cnt=0.
  - All SRAM port outputs are 0, and wr_ready/rd_ready are 0.
  - A read in flight at reset is discarded. Its Q1 is never captured.
- Write arbitration (combinational grant):
  - Among asserted wr_valid bits, the pointer-favoured requester wins; otherwise the only requester wins.
  - On grant g: wr_ready[g]=1, CE0=WE0=1, A0/D0/WEM0 come from requester g.
  - The pointer then favours the other requester from the next cycle.
  - With no grant, CE0=WE0=0 and A0/D0/WEM0=0.
- Read eligibility:
  - Requester r is eligible when rd_valid[r] && !inflight[r] && (!rsp_valid[r] || rsp_ready[r]).
  - Round-robin selection runs among eligible requesters only.
- Read conflict:
  - A conflict exists when the selected read address equals A0 while CE0&&WE0 are asserted in the same cycle.
  - On conflict: no read is issued, rd_ready=0, CE1=0, the read pointer is unchanged, and stall_cnt increments (saturating). The write proceeds.
- Read issue:
  - rd_ready[g]=1, CE1=1, A1=rd_addr[g], inflight[g] is set for exactly one cycle, and the read pointer flips.
  - When idle: CE1=0 and A1=0.
- Response path:
  - At the edge ending the cycle after issue (cycle t+1), Q1 is registered into rsp_data[g] and rsp_valid[g] is set.
  - rsp_valid is visible from cycle t+2, so issue-to-response latency is 2 cycles.
  - rsp_valid[r] clears on rsp_valid&&rsp_ready unless a capture for r happens on the same edge; capture wins and the slot stays full.
- Throughput:
  - One write per cycle in aggregate.
  - One read per cycle in aggregate when both requesters alternate; one read per 2 cycles for a single requester.
- Read-after-write: a deferred read reissued the next cycle returns the newly written data.
- Simultaneous events:
  - Both requesters may hold the write and read ports in the same cycle, provided the addresses differ.
  - The write and read pointers are independent.

Decomposition:
- Shared package sram_b_arb_pkg:
  - NREQ=2.
  - SRAM_RD_LAT=1.
  - Requester index type.
- Sub-module rr_arb2: two-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: gnt[1:0] one-hot, plus the internal pointer register.
  - Pointer flips on advance; asynchronous active-high reset favours requester 0.
  - Instantiated twice: write port and read port.

Test Plan:
- Reset, then both wr_valid held at addr 0x10/0x20 for 4 cycles -> wr_ready sequence is 01,10,01,10; CE0=WE0=1 every cycle; memory holds the last data at each address.
- Requester 0 writes 0xA5 to 0x33; next cycle requester 0 reads 0x33 with rsp_ready=1 -> rd_ready[0]=1 at t, CE1=1/A1=0x33 at t, rsp_valid[0]=1 with rsp_data=0xA5 at t+2.
- Same-cycle write 0x5A and read to 0x40 -> rd_ready=0, CE1=0, stall_cnt=1; read issues the next cycle and returns 0x5A.
- Requester 1 reads with rsp_ready[1]=0 -> rsp_valid[1] stays high with stable data and rd_ready[1] stays 0 until rsp_ready pulses; a new read issues the same cycle the slot drains.
- Both requesters read continuously with rsp_ready=1 -> CE1 high every cycle, grants alternate 01/10, each requester gets 1 response per 2 cycles in order.
- RST asserted the cycle after a read issue -> rsp_valid stays 0 after release, pointers favour requester 0, and stall_cnt=0.
